key_enable_gen: RTL and testbench

Debounced push-button front end that produces the single-cycle `enable` strobe consumed by the 2-bit lab counter. It sits directly upstream of the counter on the board: the raw key input enters here, and `enable` drives the counter's enable input, so each physical press advances the count by exactly one. An optional auto-repeat mode issues further strobes while the key is held.

---
 rtl/key_enable_gen.sv | 162 ++++++++++++++++
 tb/tb_key_enable_gen.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/key_enable_gen.sv
// Debounced key front end producing a one-cycle enable strobe per accepted press.
// Define KEY_AUTO_REPEAT_EN to build the auto-repeat strobes while the key is held.
module key_enable_gen #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int REPEAT_DELAY    = 8,
  parameter int REPEAT_PERIOD   = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_in,
  output logic       enable,
  output logic       btn_level,
  output logic [7:0] pulse_count
);

  localparam int DB_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
    $error("key_enable_gen: DEBOUNCE_CYCLES must be >= 2");
  end
  if (REPEAT_DELAY < 1) begin : g_bad_delay
    $error("key_enable_gen: REPEAT_DELAY must be >= 1");
  end
  if (REPEAT_PERIOD < 1) begin : g_bad_period
    $error("key_enable_gen: REPEAT_PERIOD must be >= 1");
  end

  typedef enum logic {
    IDLE = 1'b0,
    HELD = 1'b1
  } state_t;

  logic            s1;
  logic            btn_sync;
  logic [DB_W-1:0] db_cnt;
  logic            level_toggle;
  logic            level_rise;
  logic            level_fall;
  state_t          state;
  state_t          state_nxt;
  logic            strobe;

  // Stage: two-flop synchroniser for the asynchronous key input
  always_ff @(posedge clk) begin
    if (reset) begin
      s1       <= 1'b0;
      btn_sync <= 1'b0;
    end else begin
      s1       <= btn_in;
      btn_sync <= s1;
    end
  end

  // Stage: debounce, level accepted after DEBOUNCE_CYCLES consecutive disagreeing samples
  always_comb begin
    level_toggle = (btn_sync != btn_level) && (db_cnt == DB_LAST);
    level_rise   = level_toggle && !btn_level;
    level_fall   = level_toggle && btn_level;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      db_cnt    <= '0;
      btn_level <= 1'b0;
    end else if (btn_sync == btn_level) begin
      db_cnt    <= '0;
    end else if (level_toggle) begin
      db_cnt    <= '0;
      btn_level <= ~btn_level;
    end else begin
      db_cnt    <= db_cnt + 1'b1;
    end
  end

`ifdef KEY_AUTO_REPEAT_EN
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RPT_W   = (RPT_MAX > 2) ? $clog2(RPT_MAX) : 1;
  localparam logic [RPT_W-1:0] DELAY_LAST  = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] PERIOD_LAST = RPT_W'(REPEAT_PERIOD - 1);

  logic [RPT_W-1:0] rpt_cnt;
  logic [RPT_W-1:0] rpt_cnt_nxt;
  logic             rpt_periodic;
  logic             rpt_periodic_nxt;
  logic             rpt_hit;

  // rpt_periodic selects the repeat period once the initial delay has elapsed
  always_comb begin
    rpt_hit = rpt_periodic ? (rpt_cnt == PERIOD_LAST) : (rpt_cnt == DELAY_LAST);
  end
`endif

  // Stage: press FSM and strobe generation
  always_comb begin
    state_nxt = state;
    strobe    = 1'b0;
`ifdef KEY_AUTO_REPEAT_EN
    rpt_cnt_nxt      = rpt_cnt;
    rpt_periodic_nxt = rpt_periodic;
`endif
    case (state)
      IDLE: begin
        if (level_rise) begin
          state_nxt = HELD;
          strobe    = 1'b1;
`ifdef KEY_AUTO_REPEAT_EN
          rpt_cnt_nxt      = '0;
          rpt_periodic_nxt = 1'b0;
`endif
        end
      end
      HELD: begin
        // A release on a repeat edge takes priority and suppresses the strobe
        if (level_fall) begin
          state_nxt = IDLE;
        end else begin
`ifdef KEY_AUTO_REPEAT_EN
          if (rpt_hit) begin
            strobe           = 1'b1;
            rpt_cnt_nxt      = '0;
            rpt_periodic_nxt = 1'b1;
          end else begin
            rpt_cnt_nxt      = rpt_cnt + 1'b1;
          end
`endif
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
`ifdef KEY_AUTO_REPEAT_EN
      rpt_cnt      <= '0;
      rpt_periodic <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
`ifdef KEY_AUTO_REPEAT_EN
      rpt_cnt      <= rpt_cnt_nxt;
      rpt_periodic <= rpt_periodic_nxt;
`endif
    end
  end

  // Stage: registered strobe and wrapping strobe counter
  always_ff @(posedge clk) begin
    if (reset) begin
      enable      <= 1'b0;
      pulse_count <= 8'd0;
    end else begin
      enable <= strobe;
      if (strobe) begin
        pulse_count <= pulse_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_key_enable_gen.sv
// Self-checking bench for key_enable_gen: behavioural model compare plus directed literal checks.
module tb_key_enable_gen;

  localparam int DEB = 4;
  localparam int RD  = 8;
  localparam int RP  = 4;

  logic       clk;
  logic       reset;
  logic       btn_in;
  logic       enable;
  logic       btn_level;
  logic [7:0] pulse_count;

  int checks   = 0;
  int failures = 0;
  bit chk_on   = 0;

  key_enable_gen #(
    .DEBOUNCE_CYCLES(DEB),
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .btn_in     (btn_in),
    .enable     (enable),
    .btn_level  (btn_level),
    .pulse_count(pulse_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at time %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Behavioural model: the accepted level follows the synchronised key once it has
  // disagreed for DEB consecutive samples; strobe on each accepted press, and with
  // auto-repeat at RD edges after the press and every RP edges after that.
  int m_s1, m_sync, m_lvl, m_run, m_held, m_en, m_cnt;
  always @(posedge clk) begin
    int new_lvl;
    if (reset) begin
      m_s1 = 0; m_sync = 0; m_lvl = 0; m_run = 0; m_held = 0; m_en = 0; m_cnt = 0;
    end else begin
      m_run   = (m_sync != m_lvl) ? m_run + 1 : 0;
      new_lvl = m_lvl;
      if (m_run == DEB) begin
        new_lvl = 1 - m_lvl;
        m_run   = 0;
      end
      m_en = 0;
      if (new_lvl == 1 && m_lvl == 0) begin
        m_en   = 1;
        m_held = 0;
      end else if (new_lvl == 1 && m_lvl == 1) begin
        m_held++;
`ifdef KEY_AUTO_REPEAT_EN
        if (m_held >= RD && ((m_held - RD) % RP) == 0) m_en = 1;
`endif
      end
      if (m_en == 1) m_cnt = (m_cnt + 1) % 256;
      m_lvl  = new_lvl;
      m_sync = m_s1;
      m_s1   = int'(btn_in);
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("model_enable", int'(enable), m_en);
      chk("model_btn_level", int'(btn_level), m_lvl);
      chk("model_pulse_count", int'(pulse_count), m_cnt);
    end
  end

  initial begin
    int c0;
    bit en_seen;
    int offs[$];
    int exp_offs[6];
    exp_offs = '{8, 12, 16, 20, 24, 28};

    reset  = 1'b1;
    btn_in = 1'b0;
    cyc(2);
    chk_on = 1;
    chk("reset_enable", int'(enable), 0);
    chk("reset_btn_level", int'(btn_level), 0);
    chk("reset_pulse_count", int'(pulse_count), 0);
    reset = 1'b0;
    cyc(2);

    // Clean press: strobe and level rise on edge 6 after the first high sample
    btn_in = 1'b1;
    cyc(5);
    chk("press_level_before_e6", int'(btn_level), 0);
    chk("press_enable_before_e6", int'(enable), 0);
    cyc(1);
    chk("press_enable_e6", int'(enable), 1);
    chk("press_level_e6", int'(btn_level), 1);
    chk("press_count_e6", int'(pulse_count), 1);
    chk("press_model_count", m_cnt, 1);
    cyc(1);
    chk("press_enable_e7", int'(enable), 0);
    cyc(13);

    // Release: level falls 6 edges after the key drops, with no strobe
    btn_in = 1'b0;
    cyc(5);
    chk("release_level_before_e6", int'(btn_level), 1);
    cyc(1);
    chk("release_level_e6", int'(btn_level), 0);
    chk("release_enable_e6", int'(enable), 0);
    cyc(2);

    // Second press adds exactly one strobe
    c0 = int'(pulse_count);
    btn_in = 1'b1;
    cyc(6);
    chk("press2_enable", int'(enable), 1);
    chk("press2_count", int'(pulse_count), (c0 + 1) % 256);
    cyc(4);

    // Reset while held with level high, then a fresh strobe after re-debounce
    chk("midhold_level_pre", int'(btn_level), 1);
    reset = 1'b1;
    cyc(1);
    chk("midhold_reset_enable", int'(enable), 0);
    chk("midhold_reset_level", int'(btn_level), 0);
    chk("midhold_reset_count", int'(pulse_count), 0);
    reset = 1'b0;
    cyc(5);
    chk("midhold_enable_before_e6", int'(enable), 0);
    cyc(1);
    chk("midhold_enable_e6", int'(enable), 1);
    chk("midhold_count_e6", int'(pulse_count), 1);
    btn_in = 1'b0;
    cyc(10);

    // Bounce: two-cycle runs never satisfy the debounce window
    c0 = int'(pulse_count);
    en_seen = 0;
    for (int i = 0; i < 10; i++) begin
      btn_in = ~btn_in;
      for (int j = 0; j < 2; j++) begin
        cyc(1);
        if (enable) en_seen = 1;
      end
    end
    btn_in = 1'b0;
    for (int j = 0; j < 8; j++) begin
      cyc(1);
      if (enable) en_seen = 1;
    end
    chk("bounce_enable_seen", int'(en_seen), 0);
    chk("bounce_level", int'(btn_level), 0);
    chk("bounce_count", int'(pulse_count), c0);

`ifdef KEY_AUTO_REPEAT_EN
    // Auto-repeat: strobes at E, E+8, E+12, ..., E+28 while held
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    btn_in = 1'b1;
    cyc(6);
    chk("repeat_initial_enable", int'(enable), 1);
    for (int i = 1; i <= 30; i++) begin
      cyc(1);
      if (enable) offs.push_back(i);
    end
    chk("repeat_strobe_total", offs.size(), 6);
    for (int k = 0; k < 6; k++) begin
      if (k < offs.size()) chk("repeat_offset", offs[k], exp_offs[k]);
    end
    chk("repeat_count", int'(pulse_count), 7);
    btn_in = 1'b0;
    cyc(10);
`endif

    // Wrap: 257 presses walk the counter through 255 -> 0 -> 1
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    for (int p = 1; p <= 257; p++) begin
      btn_in = 1'b1;
      cyc(8);
      btn_in = 1'b0;
      cyc(8);
      if (p >= 254) chk("wrap_count", int'(pulse_count), p % 256);
    end
    chk("wrap_model_count", m_cnt, 1);

    chk_on = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
